// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction fetch stage.
// The optional predecode feature is controlled by FETCH_PREDECODE_JUMP_EN.
package fetch_stage_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

    // J-format target: upper nibble of the sequential PC plus the word index
    function automatic logic [31:0] jump_target(input logic [3:0]  pc4_hi,
                                                input logic [25:0] index);
        return {pc4_hi, index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry buffer parking a fetched instruction and its PC+4 while decode stalls.
module fetch_hold_buf
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc4_in,
    output logic [31:0] instr,
    output logic [31:0] pc4,
    output logic        valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr <= NOP_INSTR;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (clear) begin
            instr <= NOP_INSTR;
            pc4   <= 32'h0;
            valid <= 1'b0;
        end else if (load) begin
            instr <= instr_in;
            pc4   <= pc4_in;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding imem request, IF/ID register, redirects.
// Define FETCH_PREDECODE_JUMP_EN to resolve J instructions at fetch time.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [5:0]  Opcode,
    output logic [5:0]  Funct,
    output logic        FetchErr
);

    localparam int            CW  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(MEM_TIMEOUT);

    fetch_state_e  state, state_next;
    logic [31:0]   pcf, pcf_next, pcf_plus4;
    logic [CW-1:0] tmo_cnt;
    logic          if_load, if_bubble, hb_load, hb_clear, hb_valid;
    logic [31:0]   if_instr_in, if_pc4_in, hb_instr, hb_pc4;
    logic [31:0]   seq_resp, seq_hold, redirect_target;
    logic          jump_eff, redirect, counting;

    assign pcf_plus4 = pcf + 32'd4;
    assign imem_addr = pcf;
    assign Opcode    = InstrD[31:26];
    assign Funct     = InstrD[5:0];

`ifdef FETCH_PREDECODE_JUMP_EN
    // A J already steered by predecode must not be redirected again from decode
    logic predec_d;
    assign seq_resp = (imem_rdata[31:26] == OP_J) ?
                      jump_target(pcf_plus4[31:28], imem_rdata[25:0]) : pcf_plus4;
    assign seq_hold = (hb_instr[31:26] == OP_J) ?
                      jump_target(hb_pc4[31:28], hb_instr[25:0]) : hb_pc4;
    assign jump_eff = JumpD && !predec_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           predec_d <= 1'b0;
        else if (if_bubble) predec_d <= 1'b0;
        else if (if_load)   predec_d <= (if_instr_in[31:26] == OP_J);
    end
`else
    assign seq_resp = pcf_plus4;
    assign seq_hold = hb_pc4;
    assign jump_eff = JumpD;
`endif

    assign redirect        = !StallD && (PCSrcD || jump_eff);
    assign redirect_target = PCSrcD ? PCBranchD : jump_target(PCPlus4D[31:28], InstrD[25:0]);
    assign counting        = (state == REQ) || (state == DROP);

    always_comb begin
        state_next  = state;
        pcf_next    = pcf;
        imem_req    = 1'b0;
        if_load     = 1'b0;
        if_bubble   = 1'b0;
        if_instr_in = imem_rdata;
        if_pc4_in   = pcf_plus4;
        hb_load     = 1'b0;
        hb_clear    = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (redirect) begin
                    // A response arriving with the redirect belongs to the old path
                    pcf_next   = redirect_target;
                    if_bubble  = 1'b1;
                    hb_clear   = 1'b1;
                    state_next = imem_valid ? REQ : DROP;
                end else if (imem_valid && StallD) begin
                    hb_load    = 1'b1;
                    state_next = HOLD;
                end else if (imem_valid) begin
                    if_load  = 1'b1;
                    pcf_next = seq_resp;
                end else if (!StallD) begin
                    if_bubble = 1'b1;
                end
            end
            HOLD: begin
                if (!StallD) begin
                    hb_clear   = 1'b1;
                    state_next = REQ;
                    if (redirect) begin
                        pcf_next  = redirect_target;
                        if_bubble = 1'b1;
                    end else if (hb_valid) begin
                        if_load     = 1'b1;
                        if_instr_in = hb_instr;
                        if_pc4_in   = hb_pc4;
                        pcf_next    = seq_hold;
                    end
                end
            end
            DROP: begin
                // Old request stays asserted until its response is swallowed
                imem_req = 1'b1;
                if (redirect) pcf_next = redirect_target;
                if (!StallD) if_bubble = 1'b1;
                if (imem_valid) state_next = REQ;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pcf      <= {RESET_PC[31:2], 2'b00};
            tmo_cnt  <= '0;
            FetchErr <= 1'b0;
        end else begin
            state <= state_next;
            pcf   <= {pcf_next[31:2], 2'b00};
            if (counting) begin
                if (imem_valid)      tmo_cnt <= '0;
                else if (tmo_cnt != TMO) tmo_cnt <= tmo_cnt + CW'(1);
            end
            if (counting && !imem_valid && (tmo_cnt + CW'(1) == TMO)) FetchErr <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            InstrD   <= NOP_INSTR;
            PCPlus4D <= 32'h0;
            ValidD   <= 1'b0;
        end else if (if_bubble) begin
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (if_load) begin
            InstrD   <= if_instr_in;
            PCPlus4D <= if_pc4_in;
            ValidD   <= 1'b1;
        end
    end

    fetch_hold_buf u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (hb_load),
        .clear    (hb_clear),
        .instr_in (imem_rdata),
        .pc4_in   (pcf_plus4),
        .instr    (hb_instr),
        .pc4      (hb_pc4),
        .valid    (hb_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + randomized bench for fetch_stage against a transaction-level
// reference model and a small latency-programmable instruction memory.
module tb_fetch_stage;

    logic        clk, rst, StallD, PCSrcD, JumpD;
    logic [31:0] PCBranchD, imem_addr, imem_rdata, InstrD, PCPlus4D;
    logic        imem_req, imem_valid, ValidD, FetchErr;
    logic [5:0]  Opcode, Funct;

    fetch_stage dut (
        .clk(clk), .rst(rst), .StallD(StallD), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .JumpD(JumpD), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_valid(imem_valid), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .Opcode(Opcode), .Funct(Funct), .FetchErr(FetchErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: fetch PC, decode-register contents, parked response, drop flag
    logic [31:0] m_pc, m_instr, m_pc4, m_bi, m_bp4;
    bit          m_started, m_held, m_drop, m_vld, m_err;
    int          m_cnt;

    // memory model: accepts one request, answers mem_lat cycles later
    bit          mem_busy, mem_off, last_v;
    int          mem_wait, mem_lat;
    logic [31:0] mem_addr;
    logic [31:0] addrs[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4) return 32'h0800_0010;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s wait bound expired", tag);
    endtask

    task automatic check_outputs();
        chk("req",    32'(imem_req), 32'(m_started && !m_held));
        chk("addr",   imem_addr, m_pc);
        chk("valid",  32'(ValidD), 32'(m_vld));
        chk("instr",  InstrD, m_instr);
        if (m_vld) chk("pc4", PCPlus4D, m_pc4);
        chk("opcode", 32'(Opcode), 32'(m_instr[31:26]));
        chk("funct",  32'(Funct), 32'(m_instr[5:0]));
        chk("err",    32'(FetchErr), 32'(m_err));
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_bi = 32'h0; m_bp4 = 32'h0;
        m_started = 0; m_held = 0; m_drop = 0; m_vld = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic do_reset(input bit stale);
        StallD = 0; PCSrcD = 0; JumpD = 0; PCBranchD = 32'h0; imem_valid = 0;
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        mem_busy = 0; mem_off = 0; mem_wait = 0;
        if (stale) begin
            // a response left over from before reset lands in the first cycle
            mem_busy = 1; mem_wait = 0; mem_addr = 32'h0000_0100;
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic tick(input bit s, input bit pc, input bit j, input logic [31:0] br);
        bit          v, redir, req_now;
        logic [31:0] rd, tgt, addr_now;
        StallD = s; PCSrcD = pc; JumpD = j; PCBranchD = br;
        v  = mem_busy && (mem_wait == 0) && !mem_off;
        rd = v ? mem_word(mem_addr) : $urandom;
        imem_valid = v; imem_rdata = rd; last_v = v;
        #1;
        check_outputs();
        req_now  = m_started && !m_held;
        addr_now = m_pc;
        redir    = m_started && !s && (pc || j);
        tgt      = pc ? br : {m_pc4[31:28], m_instr[25:0], 2'b00};
        if (!m_started) begin
            m_started = 1;
        end else if (m_held) begin
            if (!s) begin
                m_held = 0;
                if (redir) begin m_pc = tgt; m_vld = 0; m_instr = 32'h0; end
                else begin m_instr = m_bi; m_pc4 = m_bp4; m_vld = 1; m_pc = m_bp4; end
            end
        end else begin
            if (v) m_cnt = 0;
            else begin m_cnt++; if (m_cnt >= 16) m_err = 1; end
            if (redir) begin
                m_pc = tgt; m_vld = 0; m_instr = 32'h0; m_drop = !v;
            end else if (m_drop) begin
                if (v) m_drop = 0;
                if (!s) begin m_vld = 0; m_instr = 32'h0; end
            end else if (v && s) begin
                m_held = 1; m_bi = rd; m_bp4 = m_pc + 32'd4;
            end else if (v) begin
                m_instr = rd; m_pc4 = m_pc + 32'd4; m_vld = 1; m_pc = m_pc + 32'd4;
            end else if (!s) begin
                m_vld = 0; m_instr = 32'h0;
            end
        end
        @(posedge clk);
        if (v) mem_busy = 0;
        else if (mem_busy) begin if (mem_wait > 0) mem_wait--; end
        else if (req_now) begin mem_busy = 1; mem_addr = addr_now; mem_wait = mem_lat - 1; end
        @(negedge clk);
    endtask

    initial begin
        int          n;
        logic [31:0] pre_instr;
        bit          s, pc, j;
        rst = 0; StallD = 0; PCSrcD = 0; JumpD = 0; PCBranchD = 0;
        imem_valid = 0; imem_rdata = 0; mem_lat = 1; last_v = 0;
        @(negedge clk);
        do_reset(0);

        // sequential stream at latency 1, then stall while 0x10 returns
        n = 0;
        while (!(m_pc == 32'h10 && mem_busy) && n < 40) begin
            tick(0, 0, 0, 0);
            if (imem_req && (addrs.size() == 0 || addrs[$] != imem_addr)) addrs.push_back(imem_addr);
            n++;
        end
        if (n >= 40) bound_fail("reach_0x10");
        chk("addr_count", 32'(addrs.size() >= 3), 32'd1);
        if (addrs.size() >= 3) begin
            chk("addr_seq0", addrs[0], 32'h0);
            chk("addr_seq1", addrs[1], 32'h4);
            chk("addr_seq2", addrs[2], 32'h8);
        end
        pre_instr = m_instr;
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 0, 0);
            chk("hold_req", 32'(imem_req), 32'd0);
            chk("hold_instr", InstrD, pre_instr);
        end
        tick(0, 0, 0, 0);
        chk("release_instr", InstrD, mem_word(32'h10));
        chk("release_pc4", PCPlus4D, 32'h14);
        chk("release_valid", 32'(ValidD), 32'd1);

        // branch while request to 0x20 is still unanswered
        mem_lat = 3;
        n = 0;
        while (!(m_pc == 32'h20 && mem_busy && mem_wait > 0) && n < 80) begin tick(0, 0, 0, 0); n++; end
        if (n >= 80) bound_fail("reach_0x20");
        tick(0, 1, 0, 32'h40);
        chk("branch_addr", imem_addr, 32'h40);
        n = 0;
        while (!m_vld && n < 30) begin tick(0, 0, 0, 0); n++; end
        if (n >= 30) bound_fail("branch_fill");
        chk("branch_instr", InstrD, mem_word(32'h40));
        chk("branch_pc4", PCPlus4D, 32'h44);

        // JumpD on the J word at 0x4
        do_reset(0);
        mem_lat = 1;
        n = 0;
        while (!(m_vld && m_pc4 == 32'h8) && n < 20) begin tick(0, 0, 0, 0); n++; end
        if (n >= 20) bound_fail("reach_jump");
        chk("jump_instr", InstrD, 32'h0800_0010);
        tick(0, 0, 1, 0);
        chk("jump_addr", imem_addr, 32'h40);

        // memory goes silent: sticky timeout
        mem_off = 1;
        for (int i = 0; i < 17; i++) tick(0, 0, 0, 0);
        chk("timeout_set", 32'(FetchErr), 32'd1);
        mem_off = 0;
        n = 0;
        last_v = 0;
        while (!last_v && n < 10) begin tick(0, 0, 0, 0); n++; end
        if (n >= 10) bound_fail("timeout_valid");
        chk("timeout_sticky", 32'(FetchErr), 32'd1);
        do_reset(0);
        chk("timeout_clear", 32'(FetchErr), 32'd0);

        // PC wrap at the top of the address space
        mem_lat = 1;
        n = 0;
        while (!m_vld && n < 20) begin tick(0, 0, 0, 0); n++; end
        if (n >= 20) bound_fail("wrap_fill");
        tick(0, 1, 0, 32'hFFFF_FFFC);
        n = 0;
        while (!(m_vld && m_pc4 == 32'h0) && n < 20) begin tick(0, 0, 0, 0); n++; end
        if (n >= 20) bound_fail("wrap_accept");
        chk("wrap_pc4", PCPlus4D, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_instr", InstrD, mem_word(32'hFFFF_FFFC));

        // reset in the middle of a request, stale response during IDLE
        mem_lat = 4;
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        do_reset(1);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
        chk("stale_addr", imem_addr, 32'h0);

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            mem_lat = $urandom_range(1, 4);
            s  = ($urandom_range(0, 9) < 3);
            pc = 0; j = 0;
            if (!s && m_vld && $urandom_range(0, 7) == 0) begin
                pc = ($urandom_range(0, 1) == 1);
                j  = !pc || ($urandom_range(0, 1) == 1);
            end
            tick(s, pc, j, $urandom & 32'hFFFF_FFFC);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter MEM_TIMEOUT, default 16: cycles waiting for imem_valid before the error flag sets.
REQ-003 clk  input  1  single clock, rising-edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 StallD  input  1  decode stage stalled; IF/ID register shall hold.
REQ-006 PCSrcD  input  1  branch taken in decode; redirect to PCBranchD.
REQ-007 PCBranchD  input  32  branch target.
REQ-008 JumpD  input  1  jump in decode; redirect to {PCPlus4D[31:28], InstrD[25:0], 2'b00}.
REQ-009 imem_req  output  1  read request, held until imem_valid.
REQ-010 imem_addr  output  32  word-aligned fetch address (PCF).
REQ-011 imem_rdata  input  32  returned instruction, qualified by imem_valid.
REQ-012 imem_valid  input  1  response strobe, at least 1 cycle after request.
REQ-013 InstrD  output  32  IF/ID instruction register.
REQ-014 PCPlus4D  output  32  IF/ID PC+4.
REQ-015 ValidD  output  1  IF/ID contents are a real instruction.
REQ-016 Opcode  output  6  InstrD[31:26], feeds control unit.
REQ-017 Funct  output  6  InstrD[5:0], feeds control unit.
REQ-018 FetchErr  output  1  sticky timeout flag.

Function
REQ-019 States SHALL be IDLE, REQ, HOLD, DROP; one outstanding request maximum.
REQ-020 IDLE: imem_req=0; SHALL go to REQ on the first clock after reset release.
REQ-021 REQ: imem_req=1, imem_addr=PCF; on imem_valid with StallD=0, IF/ID SHALL load {imem_rdata, PCF+4, ValidD=1}, PCF SHALL advance to PCF+4, and the state SHALL stay REQ.
REQ-022 REQ, imem_valid with StallD=1: data and PCF+4 SHALL go to a one-entry hold buffer, imem_req SHALL drop, and the state SHALL go to HOLD.
REQ-023 HOLD: when StallD falls, the buffer SHALL move to IF/ID, PCF SHALL advance, and the state SHALL go to REQ the next cycle.
REQ-024 Redirect (PCSrcD or JumpD, sampled only when StallD=0): PCF SHALL load the target, ValidD SHALL clear next cycle, and the hold buffer SHALL be discarded; PCSrcD SHALL win if both are asserted.
REQ-025 Redirect with an unanswered request: the state SHALL go to DROP; the next imem_valid SHALL be discarded, then the state SHALL go to REQ at the target.
REQ-026 Redirect in the same cycle as imem_valid: the response SHALL be discarded and the state SHALL go to REQ at the target.
REQ-027 StallD=1 with no redirect: InstrD, PCPlus4D and ValidD SHALL hold.
REQ-028 ValidD=0: InstrD SHALL read 0, so Opcode=Funct=0 (nop).
REQ-029 PCF+4 SHALL wrap modulo 2^32; PCF[1:0] SHALL always be 0.
REQ-030 Timeout counter: it SHALL count cycles in REQ or DROP without imem_valid, reset on valid, and set FetchErr when the count reaches MEM_TIMEOUT; FetchErr SHALL be cleared only by reset.

Reset
REQ-031 Asserting rst SHALL force immediately: PCF=RESET_PC, state IDLE, imem_req=0, InstrD=0, PCPlus4D=0, ValidD=0, hold buffer empty, counter=0, FetchErr=0.
REQ-032 Reset mid-request: any later imem_valid for that request SHALL be ignored, because the state is IDLE.

Configuration
REQ-033 Macro FETCH_PREDECODE_JUMP_EN: when defined, an accepted response with opcode 6'b000010 SHALL redirect PCF to {PCF+4[31:28], imem_rdata[25:0], 2'b00} in the same cycle. The instruction SHALL still enter IF/ID with ValidD=1, and JumpD for that instruction SHALL be ignored.
REQ-034 When FETCH_PREDECODE_JUMP_EN is undefined, jumps SHALL be resolved only via JumpD.

Structure
REQ-035 A shared package SHALL hold the opcode constants (OP_RTYPE 000000, OP_LW 100011, OP_SW 101011, OP_ADDI 001000, OP_BEQ 000100, OP_J 000010), the state enum and NOP_INSTR=32'h0.
REQ-036 One sub-module, fetch_hold_buf, SHALL hold the one-entry instruction/PC+4 buffer with load/clear/valid.

Verification
REQ-037 Reset release with RESET_PC=0 and memory latency 1 -> imem_addr SHALL step 0,4,8, and ValidD SHALL be 1 from the third cycle.
REQ-038 StallD=1 for 3 cycles while the response for 0x10 returns -> HOLD, imem_req=0, IF/ID unchanged; after release, InstrD SHALL equal the word at 0x10 and PCPlus4D SHALL be 0x14.
REQ-039 PCSrcD=1 with PCBranchD=0x40 while a request to 0x20 is pending -> the response for 0x20 SHALL be dropped and the next imem_addr SHALL be 0x40.
REQ-040 JumpD with InstrD=32'h0800_0010 and PCPlus4D=0x8 -> next imem_addr SHALL be 0x40.
REQ-041 No imem_valid for 16 cycles -> FetchErr=1, still 1 after a later valid, cleared by rst.
REQ-042 PCF=32'hFFFF_FFFC, response accepted -> PCF SHALL wrap to 0 and PCPlus4D SHALL be 0.
